// File: rtl/elbuf_pkg.sv
// rtl/elbuf_pkg.sv - shared helpers for the elastic-buffer family.
package elbuf_pkg;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic logic fire(input logic req, input logic ack);
    return req & ack;
  endfunction

endpackage

// File: rtl/elbuf_fifo.sv
// rtl/elbuf_fifo.sv - DEPTH-entry storage with pointers, occupancy and registered target accept.
module elbuf_fifo
  import elbuf_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic             empty,
  output logic [CNT_W-1:0] level,
  output logic             t_ack
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CNT_W'(1);
    else if (!push && pop)
      count_next = count - CNT_W'(1);
  end

  // Accept is computed from next occupancy so it never depends combinationally on the consumers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      t_ack  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      t_ack <= (count_next != FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign level = count;

endmodule

// File: rtl/elbuf_fork.sv
// rtl/elbuf_fork.sv - elastic buffer feeding an eager fork of NI initiator channels.
module elbuf_fork
  import elbuf_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  parameter int NI    = 2,
  localparam int CNT_W = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             t_req,
  output logic             t_ack,
  input  logic [W-1:0]     t_data,
  output logic [NI-1:0]    i_req,
  input  logic [NI-1:0]    i_ack,
  output logic [W-1:0]     i_data,
  output logic [CNT_W-1:0] level
);

  logic          push;
  logic          pop;
  logic          empty;
  logic [NI-1:0] done;
  logic [NI-1:0] f;

  elbuf_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (t_data),
    .pop   (pop),
    .head  (i_data),
    .empty (empty),
    .level (level),
    .t_ack (t_ack)
  );

  assign push  = fire(t_req, t_ack);
  assign i_req = empty ? '0 : ~done;

  always_comb begin
    f = '0;
    for (int j = 0; j < NI; j++)
      f[j] = fire(i_req[j], i_ack[j]);
  end

  // The head retires once every channel has it, either from an earlier cycle or this one.
  assign pop = !empty && (&(done | f));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      done <= '0;
    else if (pop)
      done <= '0;
    else
      done <= done | f;
  end

endmodule

// File: tb/tb_elbuf_fork.sv
// tb/tb_elbuf_fork.sv - table-driven and scoreboarded checks of elbuf_fork.
module tb_elbuf_fork;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        a_treq = 1'b0;
  logic        a_tack;
  logic [31:0] a_tdata = '0;
  logic [1:0]  a_ireq;
  logic [1:0]  a_iack = '0;
  logic [31:0] a_idata;
  logic [1:0]  a_level;

  logic        b_treq = 1'b0;
  logic        b_tack;
  logic [31:0] b_tdata = '0;
  logic [0:0]  b_ireq;
  logic [0:0]  b_iack = '0;
  logic [31:0] b_idata;
  logic [2:0]  b_level;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_a[$];
  logic [31:0] got_a0[$];
  logic [31:0] got_a1[$];
  logic [31:0] exp_b[$];
  logic [31:0] got_b[$];

  typedef struct {
    logic        treq;
    logic [31:0] tdata;
    logic [1:0]  iack;
    logic        exp_tack;
    logic [1:0]  exp_ireq;
    logic        chk_data;
    logic [31:0] exp_data;
    logic [1:0]  exp_level;
  } vec_t;

  vec_t tbl[8];

  elbuf_fork #(.W(32), .DEPTH(2), .NI(2)) dut_a (
    .clk(clk), .reset(rst), .t_req(a_treq), .t_ack(a_tack), .t_data(a_tdata),
    .i_req(a_ireq), .i_ack(a_iack), .i_data(a_idata), .level(a_level)
  );

  elbuf_fork #(.W(32), .DEPTH(4), .NI(1)) dut_b (
    .clk(clk), .reset(rst), .t_req(b_treq), .t_ack(b_tack), .t_data(b_tdata),
    .i_req(b_ireq), .i_ack(b_iack), .i_data(b_idata), .level(b_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Records transfers the coming edge will perform, then advances to just after that edge.
  task automatic tick();
    if (a_treq && a_tack) exp_a.push_back(a_tdata);
    if (a_ireq[0] && a_iack[0]) got_a0.push_back(a_idata);
    if (a_ireq[1] && a_iack[1]) got_a1.push_back(a_idata);
    if (b_treq && b_tack) exp_b.push_back(b_tdata);
    if (b_ireq[0] && b_iack[0]) got_b.push_back(b_idata);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    exp_a.delete(); got_a0.delete(); got_a1.delete();
    exp_b.delete(); got_b.delete();
  endtask

  task automatic check_stream_a(input string nm);
    check({nm, " ch0 count"}, got_a0.size(), exp_a.size());
    check({nm, " ch1 count"}, got_a1.size(), exp_a.size());
    for (int i = 0; i < exp_a.size(); i++) begin
      if (i < got_a0.size()) check({nm, " ch0 word"}, got_a0[i], exp_a[i]);
      if (i < got_a1.size()) check({nm, " ch1 word"}, got_a1[i], exp_a[i]);
    end
    clear_queues();
  endtask

  initial begin
    int pushed;
    int cyc;
    logic did;
    logic [31:0] words[100];
    logic [31:0] wb[6];

    tbl[0] = '{1'b1, 32'hA, 2'b01, 1'b1, 2'b00, 1'b0, 32'h0, 2'd0};
    tbl[1] = '{1'b1, 32'hB, 2'b01, 1'b1, 2'b11, 1'b1, 32'hA, 2'd1};
    tbl[2] = '{1'b1, 32'hC, 2'b01, 1'b0, 2'b10, 1'b1, 32'hA, 2'd2};
    tbl[3] = '{1'b1, 32'hC, 2'b01, 1'b0, 2'b10, 1'b1, 32'hA, 2'd2};
    tbl[4] = '{1'b1, 32'hC, 2'b11, 1'b0, 2'b10, 1'b1, 32'hA, 2'd2};
    tbl[5] = '{1'b1, 32'hC, 2'b11, 1'b1, 2'b11, 1'b1, 32'hB, 2'd1};
    tbl[6] = '{1'b0, 32'h0, 2'b11, 1'b1, 2'b11, 1'b1, 32'hC, 2'd1};
    tbl[7] = '{1'b0, 32'h0, 2'b11, 1'b1, 2'b00, 1'b0, 32'h0, 2'd0};

    // Reset held, then released.
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst t_ack", a_tack, 0);
      check("rst i_req", a_ireq, 0);
      check("rst level", a_level, 0);
    end
    rst = 1'b0;
    check("release t_ack before edge", a_tack, 0);
    tick();
    check("release t_ack a", a_tack, 1);
    check("release t_ack b", b_tack, 1);
    check("idle i_req", a_ireq, 0);
    check("idle level", a_level, 0);

    // Back-to-back throughput with both consumers ready.
    a_iack = 2'b11;
    for (int k = 0; k < 17; k++) begin
      a_treq  = (k < 16);
      a_tdata = 32'(k + 1);
      check("tp t_ack", a_tack, 1);
      check("tp level<=1", 32'(a_level <= 2'd1), 1);
      if (k >= 1) begin
        check("tp i_req", a_ireq, 2'b11);
        check("tp i_data", a_idata, 32'(k));
      end
      tick();
    end
    a_treq = 1'b0;
    check("tp drained i_req", a_ireq, 0);
    check_stream_a("tp");

    // Slow channel 1 holds the head; buffer fills behind it.
    for (int r = 0; r < 8; r++) begin
      a_treq  = tbl[r].treq;
      a_tdata = tbl[r].tdata;
      a_iack  = tbl[r].iack;
      check($sformatf("tbl%0d t_ack", r), a_tack, tbl[r].exp_tack);
      check($sformatf("tbl%0d i_req", r), a_ireq, tbl[r].exp_ireq);
      check($sformatf("tbl%0d level", r), a_level, tbl[r].exp_level);
      if (tbl[r].chk_data) check($sformatf("tbl%0d i_data", r), a_idata, tbl[r].exp_data);
      tick();
    end
    check_stream_a("tbl");

    // Alternating consumer readiness with random words.
    for (int i = 0; i < 100; i++) words[i] = $urandom;
    pushed = 0;
    cyc = 0;
    while (cyc < 2000 && !(pushed == 100 && got_a0.size() == 100 && got_a1.size() == 100)) begin
      a_iack  = (cyc % 2 == 0) ? 2'b01 : 2'b10;
      a_treq  = (pushed < 100);
      a_tdata = (pushed < 100) ? words[pushed] : 32'h0;
      did = a_treq && a_tack;
      tick();
      if (did) pushed++;
      cyc++;
    end
    a_treq = 1'b0;
    check("alt completed in budget", 32'(cyc < 2000), 1);
    check("alt first word", exp_a.size() > 0 ? exp_a[0] : 32'hx, words[0]);
    check_stream_a("alt");

    // Asynchronous reset with two words held and channel 0 already served.
    a_iack  = 2'b01;
    a_treq  = 1'b1;
    a_tdata = 32'h11;
    tick();
    a_tdata = 32'h22;
    tick();
    a_treq = 1'b0;
    check("pre-rst level", a_level, 2);
    check("pre-rst i_req", a_ireq, 2'b10);
    #2 rst = 1'b1;
    #1;
    check("async t_ack", a_tack, 0);
    check("async i_req", a_ireq, 0);
    check("async level", a_level, 0);
    clear_queues();
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("post-rst t_ack", a_tack, 1);
    check("post-rst i_req", a_ireq, 0);
    check("post-rst level", a_level, 0);
    a_iack  = 2'b11;
    a_treq  = 1'b1;
    a_tdata = 32'h55;
    tick();
    a_treq = 1'b0;
    tick();
    tick();
    check_stream_a("post-rst");

    // DEPTH=4 NI=1: fill, single pop, one more accept.
    for (int i = 0; i < 6; i++) wb[i] = 32'hB0 + 32'(i);
    pushed = 0;
    b_iack = 1'b0;
    for (int k = 0; k < 6; k++) begin
      b_treq  = 1'b1;
      b_tdata = wb[pushed];
      did = b_treq && b_tack;
      tick();
      if (did) pushed++;
    end
    check("fill accepted", pushed, 4);
    check("fill level", b_level, 4);
    check("fill t_ack", b_tack, 0);
    check("fill i_req", b_ireq, 1);
    check("fill head", b_idata, wb[0]);
    b_treq = 1'b0;
    b_iack = 1'b1;
    tick();
    b_iack = 1'b0;
    check("pop level", b_level, 3);
    check("pop t_ack", b_tack, 1);
    check("pop head", b_idata, wb[1]);
    b_treq  = 1'b1;
    b_tdata = wb[pushed];
    did = b_treq && b_tack;
    tick();
    if (did) pushed++;
    b_treq = 1'b0;
    check("refill accepted", pushed, 5);
    check("refill level", b_level, 4);
    check("refill t_ack", b_tack, 0);
    b_iack = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    b_iack = 1'b0;
    check("fifo count", got_b.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < got_b.size()) check("fifo word", got_b[i], wb[i]);
    check("fifo empty level", b_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
